tile_scanner: RTL and testbench
===============================

# tile_scanner

Raster sequencer that drives a `tile` edge-function evaluator through a WIDTH×HEIGHT pixel window. It issues `restart`, `stepx` and `stepy` commands, samples `inside_triangle` for each pixel, and delivers a coverage stream of `(x, y, inside)` over a valid/ready handshake. It sits between the triangle setup logic, which loads a/b/c into the tile and pulses `start`, and the downstream pixel/shading consumer.

## Interface
- `WIDTH`, 16: pixels per row, ≥1.
- `HEIGHT`, 16: rows per window, ≥1.
- `XW`, `$clog2(WIDTH)` (min 1): width of `pix_x`.
- `YW`, `$clog2(HEIGHT)` (min 1): width of `pix_y`.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: begin a scan; sampled only in IDLE.
- `busy` out 1: high from the RESTART cycle through the last pixel handshake.
- `done` out 1: one-cycle pulse after the last pixel handshake.
- `command` out 2: to the tile; 0 nop, 1 restart, 2 stepy, 3 stepx.
- `inside_triangle` in 1: from the tile, reflects the tile state for the current pixel.
- `pix_valid` out 1: pixel result valid.
- `pix_ready` in 1: consumer accepts.
- `pix_x` out XW: column of the current pixel.
- `pix_y` out YW: row of the current pixel.
- `pix_inside` out 1: equals `inside_triangle` (combinational pass-through).

## Operation
- States: IDLE, RESTART, SCAN, DONE.
- **IDLE**: `command`=0. On `start`=1, go to RESTART and clear x and y.
- **RESTART**: `command`=1 for exactly one cycle, then go to SCAN. The tile holds pixel (0,0) from the next cycle.
- **SCAN**: `pix_valid`=1. `command` is combinational on the handshake `fire = pix_valid & pix_ready`:
  - `fire` with x<WIDTH-1: `command`=3, x←x+1.
  - `fire` with x=WIDTH-1 and y<HEIGHT-1: `command`=2, x←0, y←y+1. `stepy` reloads from the tile's row start, so no reverse stepping is needed.
  - `fire` on the last pixel: `command`=0, go to DONE.
  - No `fire`: `command`=0. x, y and the tile state hold, so `pix_*` stay stable while stalled.
- **DONE**: `done`=1 and `busy`=0 for one cycle, then go to IDLE. `start` is ignored in DONE.
- `start` is ignored while `busy`.
- WIDTH=1: every advance is a `stepy`, and `stepx` is never issued.
- WIDTH=HEIGHT=1: a single pixel, then DONE.
- Reset mid-scan: returns immediately to IDLE and drops the scan. The tile is not reset; the next `start` re-issues `restart`.
- Output reset values: `command`=0, `busy`=0, `done`=0, `pix_valid`=0, `pix_x`=0, `pix_y`=0.

## Timing
- `start` in cycle t: RESTART in t+1, first `pix_valid` in t+2.
- With `pix_ready` held high, throughput is one pixel per cycle. The last handshake falls in cycle t+1+WIDTH·HEIGHT and `done` pulses in the following cycle.
- `command` is registered by the tile on the same edge that completes the handshake, so the next pixel is presented one cycle after `fire`.
- `pix_valid` never depends combinationally on `pix_ready`.

## Configuration
- `TILE_SCANNER_COUNT_EN` defined:
  - Adds output `inside_count` of width `$clog2(WIDTH*HEIGHT+1)`.
  - Cleared on `reset` and on RESTART.
  - Increments on each `fire` with `pix_inside`=1.
  - Stable from the DONE cycle until the next RESTART.
- Undefined: the port and its counter are absent; all other behaviour is identical.

## Structure
- Shared package `tile_pkg` holds:
  - Command encodings `CMD_NOP`=0, `CMD_RESTART`=1, `CMD_STEPY`=2, `CMD_STEPX`=3.
  - Edge-value width `TILE_W`=18.
  - The scanner state enum.
- Sub-module `tile_scanner_xy`: x/y raster counter with clear, advance, row-wrap, and `last` flag outputs. The FSM and command mux stay in `tile_scanner`.

## Test plan
- Drive a real `tile` with c lane0=−2, a lane0=+1, b lane0=0 and other lanes 0. Use WIDTH=4, HEIGHT=2 with `pix_ready`=1. Expect `pix_inside` 0,0,1,1,0,0,1,1, `done` at t+10, and `inside_count`=4.
- Same setup, with `pix_ready` low every other cycle. Expect identical pixel sequence, `command`=0 on every stall cycle, and `pix_*` stable while stalled.
- Check the command trace for WIDTH=3, HEIGHT=2. Expect 1,3,3,2,3,3,0 across the fire cycles.
- WIDTH=1, HEIGHT=1. Expect one pixel (0,0), no `stepx` or `stepy`, and `done` two cycles after RESTART.
- Assert `reset` at the third pixel, then pulse `start`. Expect all outputs at reset values, then a full fresh scan beginning with `restart` and (0,0).
- Pulse `start` while `busy` and during DONE. Expect no effect on the pixel sequence and no extra `restart`.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared definitions for the tile edge-function evaluator and its raster scanner.
package tile_pkg;

  localparam logic [1:0] CMD_NOP     = 2'd0;
  localparam logic [1:0] CMD_RESTART = 2'd1;
  localparam logic [1:0] CMD_STEPY   = 2'd2;
  localparam logic [1:0] CMD_STEPX   = 2'd3;

  localparam int TILE_W = 18;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESTART = 2'd1,
    ST_SCAN    = 2'd2,
    ST_DONE    = 2'd3
  } scan_state_e;

endpackage

// File: rtl/tile_scanner_xy.sv
// Raster x/y position counter for tile_scanner: clears to (0,0), advances along a row
// and wraps to the start of the next row, and flags the row end and the final pixel.
module tile_scanner_xy
  import tile_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int XW     = 4,
  parameter int YW     = 4
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          clear_i,
  input  logic          advance_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          rowEnd_o,
  output logic          last_o
);

  localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

  logic [XW-1:0] xQ, xD;
  logic [YW-1:0] yQ, yD;

  assign x_o      = xQ;
  assign y_o      = yQ;
  assign rowEnd_o = (xQ == X_MAX);
  assign last_o   = rowEnd_o && (yQ == Y_MAX);

  // The caller never advances past the last pixel, so y cannot overflow here.
  always_comb begin
    xD = xQ;
    yD = yQ;
    if (clear_i) begin
      xD = '0;
      yD = '0;
    end else if (advance_i) begin
      if (rowEnd_o) begin
        xD = '0;
        yD = yQ + YW'(1);
      end else begin
        xD = xQ + XW'(1);
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      xQ <= '0;
      yQ <= '0;
    end else begin
      xQ <= xD;
      yQ <= yD;
    end
  end

endmodule

// File: rtl/tile_scanner.sv
// Raster sequencer walking a tile evaluator over a WIDTH x HEIGHT window and streaming
// (x, y, inside) per pixel. Define TILE_SCANNER_COUNT_EN to add the inside_count output.
module tile_scanner
  import tile_pkg::*;
#(
  parameter int  WIDTH  = 16,
  parameter int  HEIGHT = 16,
  localparam int XW     = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [1:0]    command,
  input  logic          inside_triangle,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          pix_inside
`ifdef TILE_SCANNER_COUNT_EN
  ,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0] inside_count
`endif
);

  scan_state_e stateQ;
  logic busyQ, doneQ, validQ;
  logic fire, rowEnd, last;

  assign fire       = validQ & pix_ready;
  assign busy       = busyQ;
  assign done       = doneQ;
  assign pix_valid  = validQ;
  assign pix_inside = inside_triangle;

  tile_scanner_xy #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .XW    (XW),
    .YW    (YW)
  ) u_xy (
    .clock_i  (clock),
    .reset_i  (reset),
    .clear_i  ((stateQ == ST_IDLE) && start),
    .advance_i(fire && !last),
    .x_o      (pix_x),
    .y_o      (pix_y),
    .rowEnd_o (rowEnd),
    .last_o   (last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ <= ST_IDLE;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
      validQ <= 1'b0;
    end else begin
      case (stateQ)
        ST_IDLE: begin
          if (start) begin
            stateQ <= ST_RESTART;
            busyQ  <= 1'b1;
          end
        end
        ST_RESTART: begin
          stateQ <= ST_SCAN;
          validQ <= 1'b1;
        end
        ST_SCAN: begin
          if (fire && last) begin
            stateQ <= ST_DONE;
            validQ <= 1'b0;
            busyQ  <= 1'b0;
            doneQ  <= 1'b1;
          end
        end
        ST_DONE: begin
          doneQ  <= 1'b0;
          stateQ <= ST_IDLE;
        end
        default: stateQ <= ST_IDLE;
      endcase
    end
  end

  // The tile latches command on the handshake edge, so stepping must be combinational on fire.
  always_comb begin
    command = CMD_NOP;
    case (stateQ)
      ST_RESTART: command = CMD_RESTART;
      ST_SCAN: begin
        if (fire && !last) begin
          command = rowEnd ? CMD_STEPY : CMD_STEPX;
        end
      end
      default: command = CMD_NOP;
    endcase
  end

`ifdef TILE_SCANNER_COUNT_EN
  localparam int CW = $clog2(WIDTH * HEIGHT + 1);

  logic [CW-1:0] countQ, countD;

  assign inside_count = countQ;

  always_comb begin
    countD = countQ;
    if (stateQ == ST_RESTART) begin
      countD = '0;
    end else if (fire && inside_triangle) begin
      countD = countQ + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      countQ <= '0;
    end else begin
      countQ <= countD;
    end
  end
`endif

endmodule

// File: tb/tb_tile_scanner.sv
// Scoreboard bench for tile_scanner: three instances (4x2, 3x2, 1x1), each driving a
// behavioural tile model, with directed scans whose pixel streams are checked on handshake.
module tb_tile_scanner;

  typedef struct {
    int w;
    int x;
    int y;
    int ins;
    int cmd;
  } pix_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int   vectors     = 0;
  int   miscompares = 0;
  pix_t expQ[$];
  int   restartCnt[3];
  int   stepCnt[3];
  int   fireCnt[3];
  bit   stallPrev[3];
  int   savedX[3];
  int   savedY[3];
  int   savedIns[3];
  bit   stallMode = 1'b0;

  logic       startA = 1'b0, readyA = 1'b1;
  logic [1:0] cmdA;
  logic       busyA, doneA, validA, insideA, triA;
  logic [1:0] xA;
  logic [0:0] yA;

  logic       startB = 1'b0, readyB = 1'b1;
  logic [1:0] cmdB;
  logic       busyB, doneB, validB, insideB, triB;
  logic [1:0] xB;
  logic [0:0] yB;

  logic       startC = 1'b0, readyC = 1'b1;
  logic [1:0] cmdC;
  logic       busyC, doneC, validC, insideC, triC;
  logic [0:0] xC;
  logic [0:0] yC;

`ifdef TILE_SCANNER_COUNT_EN
  logic [3:0] countA;
  logic [2:0] countB;
  logic [0:0] countC;
`endif

  tile_scanner #(.WIDTH(4), .HEIGHT(2)) dutA (
    .clock(clock), .reset(reset), .start(startA), .busy(busyA), .done(doneA),
    .command(cmdA), .inside_triangle(triA), .pix_valid(validA), .pix_ready(readyA),
    .pix_x(xA), .pix_y(yA), .pix_inside(insideA)
`ifdef TILE_SCANNER_COUNT_EN
    , .inside_count(countA)
`endif
  );

  tile_scanner #(.WIDTH(3), .HEIGHT(2)) dutB (
    .clock(clock), .reset(reset), .start(startB), .busy(busyB), .done(doneB),
    .command(cmdB), .inside_triangle(triB), .pix_valid(validB), .pix_ready(readyB),
    .pix_x(xB), .pix_y(yB), .pix_inside(insideB)
`ifdef TILE_SCANNER_COUNT_EN
    , .inside_count(countB)
`endif
  );

  tile_scanner #(.WIDTH(1), .HEIGHT(1)) dutC (
    .clock(clock), .reset(reset), .start(startC), .busy(busyC), .done(doneC),
    .command(cmdC), .inside_triangle(triC), .pix_valid(validC), .pix_ready(readyC),
    .pix_x(xC), .pix_y(yC), .pix_inside(insideC)
`ifdef TILE_SCANNER_COUNT_EN
    , .inside_count(countC)
`endif
  );

  // Behavioural tile lane 0: value = c + a*x + b*y, inside when the value is non-negative.
  localparam logic signed [17:0] C_A = -18'sd2, A_A = 18'sd1, B_A = 18'sd0;
  localparam logic signed [17:0] C_B = -18'sd1, A_B = 18'sd1, B_B = 18'sd1;
  localparam logic signed [17:0] C_C = 18'sd0,  A_C = 18'sd0, B_C = 18'sd0;
  logic signed [17:0] eA = '0, rowA = '0, eB = '0, rowB = '0, eC = '0, rowC = '0;

  always @(posedge clock) begin
    case (cmdA)
      2'd1: begin eA <= C_A; rowA <= C_A; end
      2'd2: begin eA <= rowA + B_A; rowA <= rowA + B_A; end
      2'd3: eA <= eA + A_A;
      default: ;
    endcase
    case (cmdB)
      2'd1: begin eB <= C_B; rowB <= C_B; end
      2'd2: begin eB <= rowB + B_B; rowB <= rowB + B_B; end
      2'd3: eB <= eB + A_B;
      default: ;
    endcase
    case (cmdC)
      2'd1: begin eC <= C_C; rowC <= C_C; end
      2'd2: begin eC <= rowC + B_C; rowC <= rowC + B_C; end
      2'd3: eC <= eC + A_C;
      default: ;
    endcase
  end

  assign triA = ~eA[17];
  assign triB = ~eB[17];
  assign triC = ~eC[17];

  initial begin
    forever begin
      @(posedge clock);
      #1;
      readyA = stallMode ? ~readyA : 1'b1;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pushPix(input int w, input int x, input int y, input int ins, input int cmd);
    pix_t p;
    p.w = w; p.x = x; p.y = y; p.ins = ins; p.cmd = cmd;
    expQ.push_back(p);
  endtask

  // Monitor: pops one expected pixel per handshake and checks stall behaviour.
  task automatic monitorOne(input int w, input logic v, input logic r, input logic [1:0] c,
                            input int x, input int y, input logic ins);
    pix_t e;
    if (c == 2'd1) restartCnt[w]++;
    if (c == 2'd2 || c == 2'd3) stepCnt[w]++;
    if (stallPrev[w] && v) begin
      checkOutput($sformatf("dut%0d stall_x", w), x, savedX[w]);
      checkOutput($sformatf("dut%0d stall_y", w), y, savedY[w]);
      checkOutput($sformatf("dut%0d stall_inside", w), int'(ins), savedIns[w]);
    end
    stallPrev[w] = v && !r;
    if (v && !r) begin
      checkOutput($sformatf("dut%0d stall_cmd", w), int'(c), 0);
      savedX[w] = x; savedY[w] = y; savedIns[w] = int'(ins);
    end
    if (v && r) begin
      fireCnt[w]++;
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL dut%0d unexpected_pixel: got (%0d,%0d), expected none", w, x, y);
      end else begin
        e = expQ.pop_front();
        checkOutput($sformatf("dut%0d pix_source", w), w, e.w);
        checkOutput($sformatf("dut%0d pix_x", w), x, e.x);
        checkOutput($sformatf("dut%0d pix_y", w), y, e.y);
        checkOutput($sformatf("dut%0d pix_inside", w), int'(ins), e.ins);
        checkOutput($sformatf("dut%0d fire_cmd", w), int'(c), e.cmd);
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      monitorOne(0, validA, readyA, cmdA, int'(xA), int'(yA), insideA);
      monitorOne(1, validB, readyB, cmdB, int'(xB), int'(yB), insideB);
      monitorOne(2, validC, readyC, cmdC, int'(xC), int'(yC), insideC);
    end
  end

  task automatic setStart(input int w, input logic v);
    case (w)
      0: startA = v;
      1: startB = v;
      default: startC = v;
    endcase
  endtask

  function automatic logic getDone(input int w);
    case (w)
      0: return doneA;
      1: return doneB;
      default: return doneC;
    endcase
  endfunction

  function automatic logic getBusy(input int w);
    case (w)
      0: return busyA;
      1: return busyB;
      default: return busyC;
    endcase
  endfunction

  // Pulses start in cycle t and returns k such that done was seen in cycle t+k.
  task automatic applyStimulus(input int w, input bit poke, input bit pokeDone, output int k);
    @(negedge clock);
    setStart(w, 1'b1);
    @(posedge clock);
    @(negedge clock);
    setStart(w, 1'b0);
    k = 1;
    while (!getDone(w) && k < 300) begin
      setStart(w, poke && (k == 4));
      @(negedge clock);
      k++;
    end
    setStart(w, 1'b0);
    if (k >= 300) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL dut%0d done_timeout: got no done, expected done within 300 cycles", w);
    end
    if (pokeDone) begin
      setStart(w, 1'b1);
      @(negedge clock);
      setStart(w, 1'b0);
    end
  endtask

  task automatic postChecks(input int w, input int rs0);
    repeat (5) @(negedge clock);
    checkOutput($sformatf("dut%0d queue_drained", w), expQ.size(), 0);
    checkOutput($sformatf("dut%0d restart_count", w), restartCnt[w] - rs0, 1);
    checkOutput($sformatf("dut%0d idle_busy", w), int'(getBusy(w)), 0);
  endtask

  int insA[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
  int cmA[8]  = '{3, 3, 3, 2, 3, 3, 3, 0};
  int insB[6] = '{0, 1, 1, 1, 1, 1};
  int cmB[6]  = '{3, 3, 2, 3, 3, 0};

  task automatic pushScanA();
    for (int i = 0; i < 8; i++) pushPix(0, i % 4, i / 4, insA[i], cmA[i]);
  endtask

  initial begin
    int k, rs0, f0, n;
    for (int i = 0; i < 3; i++) begin
      restartCnt[i] = 0; stepCnt[i] = 0; fireCnt[i] = 0; stallPrev[i] = 1'b0;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    checkOutput("reset command", int'(cmdA), 0);
    checkOutput("reset busy", int'(busyA), 0);
    checkOutput("reset done", int'(doneA), 0);
    checkOutput("reset valid", int'(validA), 0);
    checkOutput("reset x", int'(xA), 0);
    checkOutput("reset y", int'(yA), 0);

    // 4x2 full-rate scan
    rs0 = restartCnt[0];
    pushScanA();
    applyStimulus(0, 1'b0, 1'b0, k);
    checkOutput("dutA done_latency", k, 10);
`ifdef TILE_SCANNER_COUNT_EN
    checkOutput("dutA inside_count", int'(countA), 4);
`endif
    postChecks(0, rs0);

    // 4x2 with ready toggling, start poked while busy and in DONE
    stallMode = 1'b1;
    rs0 = restartCnt[0];
    pushScanA();
    applyStimulus(0, 1'b1, 1'b1, k);
    stallMode = 1'b0;
`ifdef TILE_SCANNER_COUNT_EN
    checkOutput("dutA stall inside_count", int'(countA), 4);
`endif
    postChecks(0, rs0);

    // 3x2 command trace
    rs0 = restartCnt[1];
    for (int i = 0; i < 6; i++) pushPix(1, i % 3, i / 3, insB[i], cmB[i]);
    applyStimulus(1, 1'b0, 1'b0, k);
    checkOutput("dutB done_latency", k, 8);
`ifdef TILE_SCANNER_COUNT_EN
    checkOutput("dutB inside_count", int'(countB), 5);
`endif
    postChecks(1, rs0);

    // 1x1 single pixel
    rs0 = restartCnt[2];
    pushPix(2, 0, 0, 1, 0);
    applyStimulus(2, 1'b0, 1'b0, k);
    checkOutput("dutC done_latency", k, 3);
    checkOutput("dutC step_count", stepCnt[2], 0);
`ifdef TILE_SCANNER_COUNT_EN
    checkOutput("dutC inside_count", int'(countC), 1);
`endif
    postChecks(2, rs0);

    // Reset while the third pixel of a 4x2 scan is presented
    f0 = fireCnt[0];
    pushPix(0, 0, 0, 0, 3);
    pushPix(0, 1, 0, 0, 3);
    @(negedge clock);
    startA = 1'b1;
    @(negedge clock);
    startA = 1'b0;
    n = 0;
    while (fireCnt[0] - f0 < 2 && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    checkOutput("dutA pre_reset_fires", fireCnt[0] - f0, 2);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midreset command", int'(cmdA), 0);
    checkOutput("midreset busy", int'(busyA), 0);
    checkOutput("midreset done", int'(doneA), 0);
    checkOutput("midreset valid", int'(validA), 0);
    checkOutput("midreset x", int'(xA), 0);
    checkOutput("midreset y", int'(yA), 0);
`ifdef TILE_SCANNER_COUNT_EN
    checkOutput("midreset inside_count", int'(countA), 0);
`endif
    @(negedge clock);
    reset = 1'b0;
    rs0 = restartCnt[0];
    pushScanA();
    applyStimulus(0, 1'b0, 1'b0, k);
    checkOutput("dutA rescan done_latency", k, 10);
`ifdef TILE_SCANNER_COUNT_EN
    checkOutput("dutA rescan inside_count", int'(countA), 4);
`endif
    postChecks(0, rs0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
